// File: rtl/pktbuf_pkg.sv
// Shared packet-buffer types: page address and line write request.
// Used by the packet writers, the write arbiter and the buffer.
package pktbuf_pkg;

  localparam int PAGE_W     = 3;
  localparam int LINE_W     = 4;
  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic              pool;
    logic [PAGE_W-1:0] pageNum;
  } page_t;

  typedef struct packed {
    logic                      slot;
    page_t                     page;
    logic [LINE_W-1:0]         line;
    logic [WORD_BYTES-1:0][7:0] data;
  } write_req_t;

  function automatic logic [LINE_W-1:0] next_line(
    input logic [LINE_W-1:0] l
  );
    return l + LINE_W'(1);
  endfunction

endpackage

// File: rtl/write_req_arbiter_if.sv
// Valid/ready channel carrying one line write request.
// The master drives valid and bits, the slave drives ready.
interface write_req_arbiter_if;
  import pktbuf_pkg::*;

  logic       valid;
  logic       ready;
  write_req_t bits;

  modport master (
    output valid,
    output bits,
    input  ready
  );

  modport slave (
    input  valid,
    input  bits,
    output ready
  );

endinterface

// File: rtl/write_req_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid index at or after ptr.
// Returns the winner as both a one-hot vector and an index.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  oh_o
);

  logic [IW-1:0] j;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    oh_o  = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (!any_o && valid_i[j]) begin
        any_o   = 1'b1;
        idx_o   = j;
        oh_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_req_arbiter.sv
// Round-robin arbiter for the packet-buffer write port with a
// registered output stage and per-writer line-sequence checking.
module write_req_arbiter
  import pktbuf_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ),
  localparam int DW      = WORD_BYTES * 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        io_reqIn_valid,
  output logic [NUM_REQ-1:0]        io_reqIn_ready,
  input  logic [NUM_REQ-1:0]        io_reqIn_bits_slot,
  input  logic [NUM_REQ-1:0]        io_reqIn_bits_page_pool,
  input  logic [NUM_REQ*PAGE_W-1:0] io_reqIn_bits_page_pageNum,
  input  logic [NUM_REQ*LINE_W-1:0] io_reqIn_bits_line,
  input  logic [NUM_REQ*DW-1:0]     io_reqIn_bits_data,
  output logic                      io_writeReqOut_valid,
  input  logic                      io_writeReqOut_ready,
  output logic                      io_writeReqOut_bits_slot,
  output logic                      io_writeReqOut_bits_page_pool,
  output logic [PAGE_W-1:0]         io_writeReqOut_bits_page_pageNum,
  output logic [LINE_W-1:0]         io_writeReqOut_bits_line,
  output logic [DW-1:0]             io_writeReqOut_bits_data,
  output logic [IW-1:0]             io_grantId,
  output logic                      io_error,
  output logic [IW-1:0]             io_errorSrc
);

  write_req_t        req [NUM_REQ];
  write_req_t        sel;
  logic              any;
  logic [IW-1:0]     gnt;
  logic [NUM_REQ-1:0] gnt_oh;
  logic              load;
  logic              legal;

  logic              out_valid_q, out_valid_d;
  write_req_t        out_q, out_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] seen_q, seen_d;
  logic [LINE_W-1:0] prev_line_q [NUM_REQ];
  logic [LINE_W-1:0] prev_line_d [NUM_REQ];
  page_t             prev_page_q [NUM_REQ];
  page_t             prev_page_d [NUM_REQ];
  logic              err_q, err_d;
  logic [IW-1:0]     err_src_q, err_src_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i].slot         = io_reqIn_bits_slot[i];
      req[i].page.pool    = io_reqIn_bits_page_pool[i];
      req[i].page.pageNum = io_reqIn_bits_page_pageNum[i*PAGE_W +: PAGE_W];
      req[i].line         = io_reqIn_bits_line[i*LINE_W +: LINE_W];
      req[i].data         = io_reqIn_bits_data[i*DW +: DW];
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid_i (io_reqIn_valid),
    .ptr_i   (rr_ptr_q),
    .any_o   (any),
    .idx_o   (gnt),
    .oh_o    (gnt_oh)
  );

  assign load = !out_valid_q || io_writeReqOut_ready;
  assign sel  = req[gnt];

  // Ready is held low while reset is asserted.
  assign io_reqIn_ready = reset ? (gnt_oh & {NUM_REQ{load}}) : '0;

  assign legal = (sel.line == '0) ||
                 (seen_q[gnt] &&
                  sel.page == prev_page_q[gnt] &&
                  sel.line == next_line(prev_line_q[gnt]));

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    gid_d       = gid_q;
    rr_ptr_d    = rr_ptr_q;
    seen_d      = seen_q;
    prev_line_d = prev_line_q;
    prev_page_d = prev_page_q;
    err_d       = err_q;
    err_src_d   = err_src_q;
    if (load) begin
      out_valid_d = any;
      if (any) begin
        out_d    = sel;
        gid_d    = gnt;
        rr_ptr_d = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + IW'(1);
        seen_d[gnt]      = 1'b1;
        prev_line_d[gnt] = sel.line;
        prev_page_d[gnt] = sel.page;
        // Only the first failure is recorded.
        if (!legal && !err_q) begin
          err_d     = 1'b1;
          err_src_d = gnt;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      gid_q       <= '0;
      rr_ptr_q    <= '0;
      seen_q      <= '0;
      err_q       <= 1'b0;
      err_src_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        prev_line_q[i] <= '0;
        prev_page_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      gid_q       <= gid_d;
      rr_ptr_q    <= rr_ptr_d;
      seen_q      <= seen_d;
      err_q       <= err_d;
      err_src_q   <= err_src_d;
      prev_line_q <= prev_line_d;
      prev_page_q <= prev_page_d;
    end
  end

  write_req_arbiter_if out_if ();

  assign out_if.valid = out_valid_q;
  assign out_if.bits  = out_q;
  assign out_if.ready = io_writeReqOut_ready;

  assign io_writeReqOut_valid             = out_if.valid;
  assign io_writeReqOut_bits_slot         = out_if.bits.slot;
  assign io_writeReqOut_bits_page_pool    = out_if.bits.page.pool;
  assign io_writeReqOut_bits_page_pageNum = out_if.bits.page.pageNum;
  assign io_writeReqOut_bits_line         = out_if.bits.line;
  assign io_writeReqOut_bits_data         = out_if.bits.data;
  assign io_grantId                       = gid_q;
  assign io_error                         = err_q;
  assign io_errorSrc                      = err_src_q;

endmodule

// File: tb/tb_write_req_arbiter.sv
// Randomized and directed bench for write_req_arbiter against a
// cycle-level reference model built from per-writer request queues.
module tb_write_req_arbiter;
  import pktbuf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rq_valid = '0;
  logic [3:0]  rq_ready;
  logic [3:0]  rq_slot = '0;
  logic [3:0]  rq_pool = '0;
  logic [11:0] rq_pg = '0;
  logic [15:0] rq_line = '0;
  logic [127:0] rq_data = '0;
  logic        o_slot;
  logic        o_pool;
  logic [2:0]  o_pg;
  logic [3:0]  o_line;
  logic [31:0] o_data;
  logic [1:0]  o_gid;
  logic        o_err;
  logic [1:0]  o_src;

  write_req_arbiter_if wr_if ();

  assign wr_if.bits = {o_slot, o_pool, o_pg, o_line, o_data};

  always #5 clk = ~clk;

  write_req_arbiter dut (
    .clock                            (clk),
    .reset                            (rst_n),
    .io_reqIn_valid                   (rq_valid),
    .io_reqIn_ready                   (rq_ready),
    .io_reqIn_bits_slot               (rq_slot),
    .io_reqIn_bits_page_pool          (rq_pool),
    .io_reqIn_bits_page_pageNum       (rq_pg),
    .io_reqIn_bits_line               (rq_line),
    .io_reqIn_bits_data               (rq_data),
    .io_writeReqOut_valid             (wr_if.valid),
    .io_writeReqOut_ready             (wr_if.ready),
    .io_writeReqOut_bits_slot         (o_slot),
    .io_writeReqOut_bits_page_pool    (o_pool),
    .io_writeReqOut_bits_page_pageNum (o_pg),
    .io_writeReqOut_bits_line         (o_line),
    .io_writeReqOut_bits_data         (o_data),
    .io_grantId                       (o_gid),
    .io_error                         (o_err),
    .io_errorSrc                      (o_src)
  );

  int checks = 0;
  int errors = 0;

  // request word: {slot, pool, pageNum[2:0], line[3:0], data[31:0]}
  logic [40:0] wb [4][64];
  int          hd [4];
  int          tl [4];

  int          m_ptr, m_gid, m_src, delivered, pushed;
  logic        m_valid, m_err;
  logic [40:0] m_out;
  int          seen [4];
  int          pline [4];
  int          ppage [4];
  int          gl [4];
  int          gp [4];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [3:0] page,
                      input logic [3:0] line);
    logic [31:0] d;
    d = $urandom;
    wb[i][tl[i] % 64] = {1'($urandom % 2), page, line, d};
    tl[i]++;
    pushed++;
  endtask

  function automatic bit busy();
    for (int i = 0; i < 4; i++)
      if (hd[i] != tl[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    m_ptr = 0; m_gid = 0; m_src = 0;
    m_valid = 1'b0; m_err = 1'b0; m_out = '0;
    delivered = 0; pushed = 0;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 0; pline[i] = 0; ppage[i] = 0;
      hd[i] = 0; tl[i] = 0; gl[i] = -1; gp[i] = 0;
    end
  endtask

  task automatic seq_model(input int i, input logic [40:0] r);
    int ln;
    int pg;
    bit ok;
    ln = int'(r[35:32]);
    pg = int'(r[39:36]);
    ok = (ln == 0) ||
         (seen[i] == 1 && pg == ppage[i] && ln == pline[i] + 1);
    if (!ok && !m_err) begin
      m_err = 1'b1;
      m_src = i;
    end
    seen[i] = 1; pline[i] = ln; ppage[i] = pg;
  endtask

  task automatic chk_outs();
    chk("out_valid", 64'(wr_if.valid), 64'(m_valid));
    chk("out_bits", 64'(wr_if.bits), 64'(m_out));
    chk("grant_id", 64'(o_gid), 64'(m_gid));
    chk("error", 64'(o_err), 64'(m_err));
    chk("error_src", 64'(o_src), 64'(m_src));
  endtask

  task automatic step(input logic rdy, input logic [3:0] en);
    logic [40:0] cur [4];
    logic [3:0]  ev;
    logic        any;
    logic        load;
    int          g;
    int          j;
    chk_outs();
    ev = '0;
    for (int i = 0; i < 4; i++) begin
      if (hd[i] != tl[i]) cur[i] = wb[i][hd[i] % 64];
      else cur[i] = 41'({$urandom, $urandom});
      ev[i] = (hd[i] != tl[i]) && en[i];
      rq_slot[i]         = cur[i][40];
      rq_pool[i]         = cur[i][39];
      rq_pg[i*3 +: 3]    = cur[i][38:36];
      rq_line[i*4 +: 4]  = cur[i][35:32];
      rq_data[i*32 +: 32] = cur[i][31:0];
    end
    rq_valid    = ev;
    wr_if.ready = rdy;
    #1;
    load = !m_valid || rdy;
    any  = 1'b0;
    g    = 0;
    for (int k = 0; k < 4; k++) begin
      j = (m_ptr + k) % 4;
      if (!any && ev[j]) begin
        any = 1'b1;
        g   = j;
      end
    end
    chk("in_ready", 64'(rq_ready),
        (any && load) ? (64'd1 << g) : 64'd0);
    @(posedge clk);
    if (m_valid && rdy) delivered++;
    if (load) begin
      if (any) begin
        seq_model(g, cur[g]);
        m_out   = cur[g];
        m_gid   = g;
        m_ptr   = (g + 1) % 4;
        m_valid = 1'b1;
        hd[g]++;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy() || m_valid) && n < 200) begin
      step(1'b1, 4'hF);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
    chk_outs();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    rq_valid    = 4'hF;
    wr_if.ready = 1'b0;
    #1;
    m_clear();
    chk_outs();
    chk("rst_ready", 64'(rq_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    wr_if.ready = 1'b0;
    m_clear();
    @(negedge clk);
    do_reset();

    // single writer, full page
    for (int k = 0; k < 16; k++) push(0, 4'd2, 4'(k));
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 4'hF);
      chk("a_valid", 64'(wr_if.valid), 64'd1);
      chk("a_line", 64'(o_line), 64'(k));
    end
    drain();
    chk("a_err", 64'(o_err), 64'd0);
    chk("a_count", 64'(delivered), 64'd16);

    // fairness with all writers valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(i, 4'(i), 4'd0);
      push(i, 4'(i), 4'd1);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'hF);
      chk("fair_gid", 64'(o_gid), 64'(k % 4));
    end
    drain();

    // output stall
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) push(i, 4'(i + 8), 4'(k));
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    for (int k = 0; k < 5; k++) step(1'b0, 4'hF);
    drain();
    chk("c_count", 64'(delivered), 64'(pushed));

    // writer 2 skips lines, then writer 1 misbehaves later
    do_reset();
    push(2, 4'd3, 4'd0);
    push(2, 4'd3, 4'd3);
    drain();
    chk("d_err", 64'(o_err), 64'd1);
    chk("d_src", 64'(o_src), 64'd2);
    push(1, 4'd1, 4'd5);
    drain();
    chk("d_src_kept", 64'(o_src), 64'd2);

    // page change without restarting at line 0
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 4'd4, 4'(k));
    push(1, 4'd5, 4'd4);
    drain();
    chk("e_err", 64'(o_err), 64'd1);
    chk("e_src", 64'(o_src), 64'd1);
    do_reset();
    for (int k = 0; k < 3; k++) push(1, 4'd4, 4'(k));
    push(1, 4'd6, 4'd0);
    push(1, 4'd6, 4'd1);
    drain();
    chk("e_new_page", 64'(o_err), 64'd0);

    // async reset while stalled with an error pending
    push(0, 4'd1, 4'd5);
    push(0, 4'd1, 4'd0);
    step(1'b1, 4'hF);
    step(1'b0, 4'hF);
    chk("f_pre_err", 64'(o_err), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("f_async_valid", 64'(wr_if.valid), 64'd0);
    chk("f_async_err", 64'(o_err), 64'd0);
    chk("f_async_ready", 64'(rq_ready), 64'd0);
    m_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(1, 4'd2, 4'd0);
    push(3, 4'd2, 4'd0);
    step(1'b1, 4'hF);
    chk("f_first_gid", 64'(o_gid), 64'd1);
    drain();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (tl[i] - hd[i] < 4 && $urandom % 3 == 0) begin
          if ($urandom % 16 == 0) begin
            gl[i] = int'($urandom % 16);
          end else if (gl[i] < 0 || gl[i] == 15) begin
            gp[i] = int'($urandom % 16);
            gl[i] = 0;
          end else begin
            gl[i] = gl[i] + 1;
          end
          push(i, 4'(gp[i]), 4'(gl[i]));
        end
      end
      step($urandom % 4 != 0, 4'($urandom | ($urandom >> 8)));
    end
    drain();
    chk("rand_count", 64'(delivered), 64'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_req_arbiter.md
# write_req_arbiter

Round-robin arbiter that shares the single packet-buffer write port among `NUM_REQ` packet writers. Each writer presents line-granular write requests (slot, page pool, page number, line, data bytes); the arbiter grants at most one per cycle and forwards it through a registered output stage with valid/ready backpressure. It also checks each writer's line sequence and raises a sticky error on out-of-order writes. It sits between the packet writers and the buffer write port.

## Interface
- `NUM_REQ`, 4, number of requesting writers (≥2)
- `PAGE_W`, 3, page-number width
- `LINE_W`, 4, line-index width; a page holds 2^LINE_W lines
- `WORD_BYTES`, 4, bytes per line write, 8 bits each

Ports. Per-requester fields are packed, with requester i in slice i.

- `clock`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `io_reqIn_valid`  input  NUM_REQ  request valid per writer
- `io_reqIn_ready`  output  NUM_REQ  request accepted this cycle (one-hot or zero)
- `io_reqIn_bits_slot`  input  NUM_REQ  slot bit per writer
- `io_reqIn_bits_page_pool`  input  NUM_REQ  pool bit per writer
- `io_reqIn_bits_page_pageNum`  input  NUM_REQ*PAGE_W  page number per writer
- `io_reqIn_bits_line`  input  NUM_REQ*LINE_W  line index per writer
- `io_reqIn_bits_data`  input  NUM_REQ*WORD_BYTES*8  write data per writer
- `io_writeReqOut_valid`  output  1  forwarded request valid
- `io_writeReqOut_ready`  input  1  buffer port accepts
- `io_writeReqOut_bits_*`  output  (slot 1, page_pool 1, page_pageNum PAGE_W, line LINE_W, data WORD_BYTES*8)  forwarded request fields
- `io_grantId`  output  clog2(NUM_REQ)  index of requester held in output register
- `io_error`  output  1  sticky line-sequence error
- `io_errorSrc`  output  clog2(NUM_REQ)  requester of first error

## Operation
- Output register can load (`load`) when `!io_writeReqOut_valid || io_writeReqOut_ready`.
- Arbitration: scan valid requesters starting at `rr_ptr`, wrapping modulo NUM_REQ; the first valid one is `gnt`. `io_reqIn_ready[gnt] = load`; all other ready bits are 0. Ready never depends on a requester's own valid except through `gnt` selection.
- On accept: the output register captures the `gnt` fields and `io_grantId <= gnt`, and `rr_ptr <= (gnt+1) mod NUM_REQ`.
- `load` with no valid requester: `io_writeReqOut_valid <= 0`, and `rr_ptr` is unchanged.
- Stalled output (valid && !ready): all output bits are held stable, and no input is accepted.
- Sequence check, per requester i: registers `prev_line[i]`, `prev_page[i]` (pool+pageNum), and `seen[i]`. On accepting i, the write is legal if line==0, or if seen[i] && page==prev_page[i] && line==prev_line[i]+1 (LINE_W-bit, no wrap past 2^LINE_W-1). Otherwise, on the first failure, `io_error <= 1` and `io_errorSrc <= i`. Later errors do not overwrite either value. The prev registers update on every accept, legal or not.
- `io_error` clears only on reset.

## Timing
- Reset (async assert, sync deassert expected upstream): `io_writeReqOut_valid=0`, all out bits 0, `io_grantId=0`, `rr_ptr=0`, `seen=0`, prev regs 0, `io_error=0`, `io_errorSrc=0`, and `io_reqIn_ready` is 0 while reset is asserted.
- Latency: request accepted at edge N appears on `io_writeReqOut_*` after edge N, i.e. one cycle.
- Throughput: one request per cycle when `io_writeReqOut_ready` is held high.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…
- Simultaneous output drain and new accept in the same cycle is allowed, with no bubble.
- Reset mid-stall: the pending output is dropped and its requester is not re-granted implicitly.

## Structure
- Shared package `pktbuf_pkg`: `page_t` (pool + pageNum), `write_req_t` (slot, page_t, line, data array), width constants PAGE_W/LINE_W/WORD_BYTES. This package is shared with the packet writer and the buffer.
- One sub-module `rr_pick`: combinational round-robin priority pick (valid vector, pointer → one-hot grant + index).
- Sequence checker stays inline.

## Test plan
- Single writer 0 sends lines 0..15 of page 2 with ready=1 → 16 outputs on consecutive cycles, each 1 cycle after accept, line 0..15, `io_error`=0.
- All 4 writers valid continuously, each with an incrementing line → grantId sequence 0,1,2,3,0,1,2,3; each `io_reqIn_ready` high in its own cycle only.
- Output ready held low for 5 cycles with valid requests pending → output bits stable, all `io_reqIn_ready`=0, `rr_ptr` frozen; on release, writes resume with no loss or duplication.
- Writer 2 sends line 0 then line 3 of the same page → `io_error`=1 one cycle after the second accept, `io_errorSrc`=2; a later bad write from writer 1 leaves `io_errorSrc`=2.
- Writer 1 sends line 4 on page 5 after line 3 on page 4 → error with src 1; line 0 on a new page → no error.
- Assert reset while a stalled request is held → `io_writeReqOut_valid`=0 immediately (async), `io_error`=0; after release, the first grant goes to the lowest valid index ≥0.
